// File: rtl/cpu_wb_mem_slave.sv
// rtl/cpu_wb_mem_slave.sv - Wishbone B4 classic single-beat responder with word-addressed RAM
module cpu_wb_mem_slave #(
    parameter int                             WISHBONE_ADDR_WIDTH = 32,
    parameter int                             WISHBONE_BUS_WIDTH  = 32,
    parameter int                             MEM_DEPTH           = 1024,
    parameter logic [WISHBONE_ADDR_WIDTH-1:0] BASE_ADDR           = '0,
    parameter int                             WAIT_STATES         = 1
) (
    input  logic                            CLK_I,
    input  logic                            RST_N_I,
    input  logic                            WBS_CYC_I,
    input  logic                            WBS_STB_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]  WBS_ADR_I,
    input  logic                            WBS_WE_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]   WBS_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0] WBS_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]   WBS_DAT_O,
    output logic                            WBS_ACK_O,
    output logic                            WBS_ERR_O
);

    localparam int AW    = WISHBONE_ADDR_WIDTH;
    localparam int DW    = WISHBONE_BUS_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int LB    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDXW  = $clog2(MEM_DEPTH);

    // Window size is kept one bit wider than the address so a borrow from
    // the base subtraction always lands outside the window.
    localparam logic [AW:0]   WIN_SIZE   = (AW+1)'(MEM_DEPTH * BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = AW'(BYTES - 1);
    localparam logic [3:0]    WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [MEM_DEPTH];

    // Latched request fields
    logic [IDXW-1:0]  idx_q;
    logic             we_q;
    logic [DW-1:0]    dat_q;
    logic [BYTES-1:0] sel_q;
    logic             err_q;

    // Live decode of the bus request
    logic [AW:0]     diff;
    logic            live_err;
    logic [IDXW-1:0] live_idx;

    // Request seen by the commit logic: live fields on the accept edge
    // (zero wait states), latched fields afterwards.
    logic             accept;
    logic             commit;
    logic             req_we;
    logic             req_err;
    logic [IDXW-1:0]  req_idx;
    logic [DW-1:0]    req_dat;
    logic [BYTES-1:0] req_sel;
    logic             mem_we;
    logic             rd_load;

    // Address window, alignment and lane-enable decode
    always_comb begin
        diff     = {1'b0, WBS_ADR_I} - {1'b0, BASE_ADDR};
        live_err = (diff >= WIN_SIZE) ||
                   ((WBS_ADR_I & ALIGN_MASK) != '0) ||
                   (WBS_SEL_I == '0);
        live_idx = IDXW'(diff >> LB);
    end

    // Next-state, counter and response outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        WBS_ACK_O = 1'b0;
        WBS_ERR_O = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (WBS_CYC_I && WBS_STB_I) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!WBS_CYC_I) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                WBS_ACK_O = !err_q;
                WBS_ERR_O = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Select live or latched request and derive the RESP-entry actions
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_we  = WBS_WE_I;
            req_err = live_err;
            req_idx = live_idx;
            req_dat = WBS_DAT_I;
            req_sel = WBS_SEL_I;
        end else begin
            req_we  = we_q;
            req_err = err_q;
            req_idx = idx_q;
            req_dat = dat_q;
            req_sel = sel_q;
        end
        commit  = (state_d == ST_RESP) && (state_q != ST_RESP) && RST_N_I;
        mem_we  = commit && req_we && !req_err;
        rd_load = commit && !req_we && !req_err;
    end

    // State, counter, request latch and read-data register
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            WBS_DAT_O <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= live_idx;
                we_q  <= WBS_WE_I;
                dat_q <= WBS_DAT_I;
                sel_q <= WBS_SEL_I;
                err_q <= live_err;
            end
            if (rd_load) begin
                WBS_DAT_O <= mem[req_idx];
            end
        end
    end

    // RAM byte-lane write; contents are deliberately not reset
    always_ff @(posedge CLK_I) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_sel[i]) begin
                    mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_wb_mem_slave.sv
// tb/tb_cpu_wb_mem_slave.sv - self-checking bench for cpu_wb_mem_slave
module tb_cpu_wb_mem_slave;

    localparam int K_NORMAL = 0;
    localparam int K_ABORT  = 1;
    localparam int K_RESET  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] adr   = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel   = '0;

    logic [31:0] dat_o [2];
    logic        ack   [2];
    logic        err   [2];

    int vectors = 0;
    int fails   = 0;

    logic [31:0] model_mem [1024];
    bit          written   [1024];
    logic [31:0] exp_dat   [2];
    int          ws        [2] = '{1, 3};

    always #5 clk = ~clk;

    cpu_wb_mem_slave #(.WAIT_STATES(1)) u_ws1 (
        .CLK_I(clk), .RST_N_I(rst_n), .WBS_CYC_I(cyc), .WBS_STB_I(stb),
        .WBS_ADR_I(adr), .WBS_WE_I(we), .WBS_DAT_I(dat_i), .WBS_SEL_I(sel),
        .WBS_DAT_O(dat_o[0]), .WBS_ACK_O(ack[0]), .WBS_ERR_O(err[0])
    );

    cpu_wb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .CLK_I(clk), .RST_N_I(rst_n), .WBS_CYC_I(cyc), .WBS_STB_I(stb),
        .WBS_ADR_I(adr), .WBS_WE_I(we), .WBS_DAT_I(dat_i), .WBS_SEL_I(sel),
        .WBS_DAT_O(dat_o[1]), .WBS_ACK_O(ack[1]), .WBS_ERR_O(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_cycle(input string tag, input int c, input logic ea [2], input logic ee [2]);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s/ws%0d/c%0d ack", tag, ws[i], c), {31'b0, ack[i]}, {31'b0, ea[i]});
            check($sformatf("%s/ws%0d/c%0d err", tag, ws[i], c), {31'b0, err[i]}, {31'b0, ee[i]});
            check($sformatf("%s/ws%0d/c%0d dat", tag, ws[i], c), dat_o[i], exp_dat[i]);
        end
    endtask

    // One request: STB in cycle 0, responses expected in cycle 1+WAIT_STATES
    task automatic txn(input string tag, input int kind, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit          e;
        int          k;
        logic [31:0] rd;
        logic        ea [2];
        logic        ee [2];
        e  = (a >= 32'd4096) || ((a % 4) != 0) || (s == 4'd0);
        k  = int'(a / 4);
        rd = e ? 32'h0 : model_mem[k];
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            stb = 1'b0;
            case (kind)
                K_ABORT: cyc = 1'b0;
                K_RESET: begin
                    cyc   = (c < 2);
                    rst_n = (c != 1);
                end
                default: cyc = (c <= 4);
            endcase
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ea[i] = (kind == K_NORMAL) && (c == 1 + ws[i]) && !e;
                ee[i] = (kind == K_NORMAL) && (c == 1 + ws[i]) && e;
                if (kind == K_NORMAL && !w && !e && c == 1 + ws[i]) exp_dat[i] = rd;
                if (kind == K_RESET && c >= 2) exp_dat[i] = 32'h0;
            end
            check_cycle(tag, c, ea, ee);
        end
        if (kind == K_NORMAL && w && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[k][8*b +: 8] = d[8*b +: 8];
            end
            written[k] = 1'b1;
        end
    endtask

    initial begin
        logic ea0 [2];
        logic [31:0] a;
        logic [3:0]  s;
        logic        w;
        int          kind;
        int          idx;
        int          r;
        ea0 = '{1'b0, 1'b0};
        exp_dat = '{32'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_cycle("idle", c, ea0, ea0);
        end

        txn("wr_10",    K_NORMAL, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        txn("rd_10",    K_NORMAL, 1'b0, 32'h10, 32'h0,        4'hF);
        txn("wrb_10",   K_NORMAL, 1'b1, 32'h10, 32'h000000AA, 4'h1);
        txn("rdb_10",   K_NORMAL, 1'b0, 32'h10, 32'h0,        4'hF);
        txn("rd_mis",   K_NORMAL, 1'b0, 32'h11, 32'h0,        4'hF);
        txn("wr_0",     K_NORMAL, 1'b1, 32'h0,  32'h11111111, 4'hF);
        txn("wr_oor",   K_NORMAL, 1'b1, 32'd4096, 32'h99999999, 4'hF);
        txn("rd_0",     K_NORMAL, 1'b0, 32'h0,  32'h0,        4'hF);
        txn("wr_sel0",  K_NORMAL, 1'b1, 32'h0,  32'h55555555, 4'h0);
        txn("rd_0b",    K_NORMAL, 1'b0, 32'h0,  32'h0,        4'hF);
        txn("wr_20",    K_NORMAL, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        txn("abort_20", K_ABORT,  1'b1, 32'h20, 32'h12345678, 4'hF);
        txn("rd_20",    K_NORMAL, 1'b0, 32'h20, 32'h0,        4'hF);
        txn("wr_30",    K_NORMAL, 1'b1, 32'h30, 32'h0BADF00D, 4'hF);
        txn("rst_30",   K_RESET,  1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        txn("rd_30",    K_NORMAL, 1'b0, 32'h30, 32'h0,        4'hF);

        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 99);
            kind = (r < 8) ? K_ABORT : (r < 14) ? K_RESET : K_NORMAL;
            idx  = $urandom_range(0, 15);
            a    = 32'(idx * 4);
            w    = written[idx] ? 1'($urandom_range(0, 1)) : 1'b1;
            s    = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 9))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = 32'd4096 + 32'($urandom_range(0, 1000) * 4);
                2: s = 4'h0;
                default: ;
            endcase
            txn($sformatf("rnd%0d", n), kind, w, a, $urandom, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
